uart_tx_arbiter: RTL and testbench

Shares the single UART_Protocol transmitter among NUM_REQ byte requesters using round-robin arbitration. Issues one-cycle send pulses toward the UART and confirms that each byte was accepted (busy rises) and completed (busy falls). Enforces an inter-frame gap so no send lands in the stop bit. Sits between on-chip byte producers and the UART send/data_in/busy interface.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/rr_picker.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter: FSM state encoding,
// bit timing constant and default parameter values.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_ACC = 3'd2,
    WAIT_END = 3'd3,
    GAP      = 3'd4
  } arb_state_t;

  localparam int CLK_PER_BIT        = 40;
  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ACCEPT_TIMEOUT = 8;
  localparam int DEF_MAX_RETRY      = 3;
  localparam int DEF_GAP_CYCLES     = CLK_PER_BIT;

  // Width of a requester index; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first asserted request at or above rr_ptr,
// wrapping modulo NUM_REQ, reported as one-hot, index and valid.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    int pos;
    logic hit;
    pos    = 0;
    hit    = 1'b0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos                = (int'(rr_ptr) + k) % NUM_REQ;
      hit                = ~valid & req[IW'(pos)];
      idx                = hit ? IW'(pos) : idx;
      onehot[IW'(pos)]   = hit;
      valid              = valid | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers, with
// accept-timeout retries and an inter-frame gap after every completed frame.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ACCEPT_TIMEOUT = DEF_ACCEPT_TIMEOUT,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   err,
  output logic                 uart_send,
  output logic [7:0]           uart_data,
  input  logic                 uart_busy,
  output logic                 arb_busy
);

  localparam int IW = ptr_width(NUM_REQ);
  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] ACC_LAST  = TW'(ACCEPT_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] PTR_LAST  = IW'(NUM_REQ - 1);

  arb_state_t          state, next_state;
  logic [IW-1:0]       rr_ptr, sel, pick_idx, ptr_d;
  logic [NUM_REQ-1:0]  pick_onehot, grant_d, ack_d, err_d;
  logic                pick_valid, acc_expired;
  logic                capture, retry, done_ok, done_err;
  logic [7:0]          data_d;
  logic [TW-1:0]       acc_timer;
  logic [RW-1:0]       retry_cnt;
  logic [GW-1:0]       gap_timer;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign acc_expired = (acc_timer == ACC_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a busy UART in IDLE (frame left over from before reset) blocks arbitration
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = (!uart_busy && pick_valid) ? SEND : IDLE;
      SEND:     next_state = WAIT_ACC;
      WAIT_ACC: begin
        if (uart_busy)        next_state = WAIT_END;
        else if (acc_expired) next_state = (retry_cnt < RETRY_MAX) ? SEND : GAP;
        else                  next_state = WAIT_ACC;
      end
      WAIT_END: next_state = uart_busy ? WAIT_END : GAP;
      GAP:      next_state = (gap_timer == GAP_LAST) ? IDLE : GAP;
      default:  next_state = IDLE;
    endcase
  end

  // Output next-values, derived from the transition being taken
  always_comb begin
    capture  = (state == IDLE)     && (next_state == SEND);
    retry    = (state == WAIT_ACC) && (next_state == SEND);
    done_ok  = (state == WAIT_END) && (next_state == GAP);
    done_err = (state == WAIT_ACC) && (next_state == GAP);
    grant_d  = grant;
    data_d   = uart_data;
    ptr_d    = rr_ptr;
    if (capture) begin
      grant_d = pick_onehot;
      data_d  = req_data[{pick_idx, 3'b000} +: 8];
    end else if (done_ok || done_err) begin
      grant_d = '0;
      ptr_d   = (sel == PTR_LAST) ? '0 : sel + IW'(1);
    end else begin
      grant_d = grant;
    end
    ack_d = {NUM_REQ{done_ok}} & grant;
    err_d = {NUM_REQ{done_err}} & grant;
  end

  // Registered outputs, capture register, pointer and timers
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      ack       <= '0;
      err       <= '0;
      uart_send <= 1'b0;
      uart_data <= 8'h00;
      arb_busy  <= 1'b0;
      rr_ptr    <= '0;
      sel       <= '0;
      retry_cnt <= '0;
      acc_timer <= '0;
      gap_timer <= '0;
    end else begin
      grant     <= grant_d;
      ack       <= ack_d;
      err       <= err_d;
      uart_send <= (next_state == SEND);
      uart_data <= data_d;
      arb_busy  <= (next_state != IDLE);
      rr_ptr    <= ptr_d;
      if (capture) sel <= pick_idx;
      if (capture)    retry_cnt <= '0;
      else if (retry) retry_cnt <= retry_cnt + RW'(1);
      if (state == SEND)          acc_timer <= '0;
      else if (state == WAIT_ACC) acc_timer <= acc_timer + TW'(1);
      if (state != GAP && next_state == GAP) gap_timer <= '0;
      else if (state == GAP)                 gap_timer <= gap_timer + GW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART model, event logs and a queue-based
// round-robin service-order model; one task per scenario.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int TO    = 8;
  localparam int MR    = 3;
  localparam int GAPC  = 40;
  localparam int FRAME = 400;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   grant, ack, err;
  logic           uart_send;
  logic [7:0]     uart_data;
  logic           uart_busy;
  logic           arb_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         send_cyc[$];
  logic [7:0] send_dat[$];
  int         send_idx[$];
  int         ack_idx[$];
  int         ack_cyc[$];
  int         err_idx[$];
  int         err_cyc[$];
  int         fall_cyc[$];
  int         idle_cyc[$];
  logic [7:0] rx[$];
  int         exp_idx[$];
  int         inv_bad   = 0;
  bit         uart_en   = 1'b1;
  int         rem[N];
  int         pend[N];
  int         model_ptr = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .ACCEPT_TIMEOUT(TO), .MAX_RETRY(MR), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant), .ack(ack),
    .err(err), .uart_send(uart_send), .uart_data(uart_data), .uart_busy(uart_busy),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input int i);
    return req_data[8*i +: 8];
  endfunction

  // UART model: accepts a send 1..3 cycles later, then is busy for one 10-bit frame
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_send && uart_en) begin
        rx.push_back(uart_data);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        uart_busy = 1'b1;
        repeat (FRAME) @(negedge clk);
        uart_busy = 1'b0;
        fall_cyc.push_back(cyc);
      end
    end
  end

  // Event logger, invariant watcher and requesters (drop req after last ack/err)
  initial begin
    logic       prev_arb;
    logic [N-1:0] prev_grant;
    logic [7:0] held;
    prev_arb = 1'b0; prev_grant = '0; held = 8'h00;
    forever begin
      @(negedge clk);
      if (uart_send) begin
        send_cyc.push_back(cyc); send_dat.push_back(uart_data); send_idx.push_back(idx_of(grant));
      end
      if (|ack) begin ack_idx.push_back(idx_of(ack)); ack_cyc.push_back(cyc); end
      if (|err) begin err_idx.push_back(idx_of(err)); err_cyc.push_back(cyc); end
      if (prev_arb && !arb_busy) idle_cyc.push_back(cyc);
      if (!$onehot0(grant) || !$onehot0(ack) || !$onehot0(err) || ((|ack) && (|err))) inv_bad++;
      if (uart_send && grant == '0) inv_bad++;
      if (grant != '0 && prev_grant == '0) held = uart_data;
      else if (grant != '0 && uart_data !== held) inv_bad++;
      prev_arb = arb_busy; prev_grant = grant;
      for (int i = 0; i < N; i++) begin
        if ((ack[i] || err[i]) && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    send_cyc.delete(); send_dat.delete(); send_idx.delete(); ack_idx.delete(); ack_cyc.delete();
    err_idx.delete(); err_cyc.delete(); fall_cyc.delete(); idle_cyc.delete(); rx.delete();
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int busy_rem;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      busy_rem = 0;
      for (int k = 0; k < N; k++) busy_rem += rem[k];
      if (i > 2 && busy_rem == 0 && !arb_busy && !uart_busy) begin ok = 1'b1; break; end
    end
  endtask

  // Reference order: repeatedly serve the first pending requester at/after the pointer
  task automatic predict_order();
    int sel;
    exp_idx.delete();
    forever begin
      sel = -1;
      for (int k = 0; k < N; k++) if (sel < 0 && pend[(model_ptr + k) % N] > 0) sel = (model_ptr + k) % N;
      if (sel < 0) break;
      exp_idx.push_back(sel);
      pend[sel]--;
      model_ptr = (sel + 1) % N;
    end
  endtask

  task automatic check_service(input string tag);
    checks++;
    if (send_idx.size() != exp_idx.size() || ack_idx.size() != exp_idx.size() || rx.size() != exp_idx.size()) begin
      errors++;
      $display("FAIL %s_count: sends %0d acks %0d rx %0d, expected %0d", tag, send_idx.size(), ack_idx.size(), rx.size(), exp_idx.size());
    end else begin
      for (int k = 0; k < exp_idx.size(); k++) begin
        checks++;
        if (send_idx[k] !== exp_idx[k] || ack_idx[k] !== exp_idx[k] || rx[k] !== byte_of(exp_idx[k])) begin
          errors++;
          $display("FAIL %s_order[%0d]: grant %0d ack %0d data %h, expected req %0d data %h", tag, k, send_idx[k], ack_idx[k], rx[k], exp_idx[k], byte_of(exp_idx[k]));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; pend[i] = 0; end
    repeat (3) tick();
    checks++;
    if ({grant, ack, err, uart_send, uart_data, arb_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant %b ack %b err %b send %b data %h busy %b, expected all 0", grant, ack, err, uart_send, uart_data, arb_busy);
    end
    reset = 1'b0; model_ptr = 0;
    repeat (2) tick();
    checks++;
    if (arb_busy !== 1'b0 || uart_send !== 1'b0) begin
      errors++; $display("FAIL reset_idle: arb_busy %b send %b, expected 0 0", arb_busy, uart_send);
    end
  endtask

  task automatic test_all_four();
    bit ok;
    logic [7:0] lit [4];
    lit[0] = 8'h55; lit[1] = 8'hAA; lit[2] = 8'hFF; lit[3] = 8'h0F;
    clear_logs();
    req_data = {8'h0F, 8'hFF, 8'hAA, 8'h55};
    for (int i = 0; i < N; i++) begin pend[i] = 1; rem[i] = 1; end
    predict_order();
    req = '1;
    wait_done(5 * (FRAME + 60), ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL all_four_timeout: still busy, expected done"); end
    check_service("all_four");
    for (int k = 0; k < 4 && k < rx.size(); k++) begin
      checks++;
      if (rx[k] !== lit[k]) begin errors++; $display("FAIL all_four_rx[%0d]: got %h expected %h", k, rx[k], lit[k]); end
    end
    for (int k = 1; k < send_cyc.size() && k <= fall_cyc.size(); k++) begin
      checks++;
      // busy-fall seen next edge, GAP_CYCLES idle cycles, one capture cycle, then the send
      if (send_cyc[k] - fall_cyc[k-1] !== GAPC + 2) begin
        errors++; $display("FAIL all_four_gap[%0d]: got %0d cycles expected %0d", k, send_cyc[k] - fall_cyc[k-1], GAPC + 2);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    int t0;
    clear_logs();
    req_data[7:0] = 8'h18;
    pend[0] = 2; rem[0] = 2;
    predict_order();
    t0 = cyc; req[0] = 1'b1;
    wait_done(3 * (FRAME + 60), ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: still busy, expected done"); end
    check_service("single");
    if (send_cyc.size() >= 2 && fall_cyc.size() >= 1 && ack_cyc.size() >= 1) begin
      checks++;
      if (send_cyc[0] - t0 !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", send_cyc[0] - t0); end
      checks++;
      if (ack_cyc[0] - fall_cyc[0] !== 1) begin errors++; $display("FAIL single_ack_time: got %0d expected 1", ack_cyc[0] - fall_cyc[0]); end
      checks++;
      if (send_cyc[1] - fall_cyc[0] < GAPC) begin errors++; $display("FAIL single_gap: got %0d expected at least %0d", send_cyc[1] - fall_cyc[0], GAPC); end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    bit seen;
    clear_logs();
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
    rem[1] = 2; req[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin tick(); seen = uart_busy; end
    checks++;
    if (!seen) begin errors++; $display("FAIL fair_accept: uart_busy 0 expected 1"); end
    rem[2] = 2; req[2] = 1'b1;
    wait_done(5 * (FRAME + 60), ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fair_timeout: still busy, expected done"); end
    exp_idx.delete();
    exp_idx.push_back(1); exp_idx.push_back(2); exp_idx.push_back(1); exp_idx.push_back(2);
    model_ptr = 3;
    check_service("fair");
  endtask

  task automatic test_timeout();
    bit ok;
    int last;
    clear_logs();
    uart_en = 1'b0;
    req_data[31:24] = 8'($urandom);
    rem[3] = 1; req[3] = 1'b1;
    wait_done(400, ok);
    uart_en = 1'b1;
    model_ptr = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_done: still busy, expected done"); end
    checks++;
    if (send_cyc.size() !== 1 + MR || err_idx.size() !== 1 || ack_idx.size() !== 0) begin
      errors++; $display("FAIL timeout_counts: sends %0d errs %0d acks %0d, expected %0d 1 0", send_cyc.size(), err_idx.size(), ack_idx.size(), 1 + MR);
    end else begin
      for (int k = 1; k <= MR; k++) begin
        checks++;
        if (send_cyc[k] - send_cyc[k-1] !== TO + 1) begin
          errors++; $display("FAIL timeout_spacing[%0d]: got %0d expected %0d", k, send_cyc[k] - send_cyc[k-1], TO + 1);
        end
      end
      last = send_cyc[MR];
      checks++;
      if (err_idx[0] !== 3 || err_cyc[0] - last !== TO + 1) begin
        errors++; $display("FAIL timeout_err: req %0d after %0d, expected req 3 after %0d", err_idx[0], err_cyc[0] - last, TO + 1);
      end
      checks++;
      if (idle_cyc.size() < 1 || idle_cyc[idle_cyc.size()-1] - err_cyc[0] !== GAPC) begin
        errors++; $display("FAIL timeout_gap: idle events %0d, expected idle %0d cycles after err", idle_cyc.size(), GAPC);
      end
    end
  endtask

  task automatic test_capture();
    bit ok;
    bit seen;
    clear_logs();
    req_data[7:0] = 8'h51;
    rem[0] = 1; req[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = grant[0]; end
    checks++;
    if (!seen) begin errors++; $display("FAIL capture_grant: grant %b expected bit0", grant); end
    tick();
    req_data[7:0] = 8'h96;
    wait_done(2 * (FRAME + 60), ok);
    model_ptr = 1;
    checks++;
    if (!ok || rx.size() !== 1 || ack_idx.size() !== 1) begin
      errors++; $display("FAIL capture_count: rx %0d acks %0d, expected 1 1", rx.size(), ack_idx.size());
    end else begin
      checks++;
      if (rx[0] !== 8'h51) begin errors++; $display("FAIL capture_data: got %h expected 51", rx[0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit seen;
    int n0;
    logic [7:0] d;
    clear_logs();
    d = 8'($urandom); req_data[23:16] = d;
    rem[2] = 1; req[2] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin tick(); seen = uart_busy && (grant != '0); end
    repeat ($urandom_range(2, 50)) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_ptr = 0;
    checks++;
    if (!seen || {grant, ack, err, uart_send, uart_data, arb_busy} !== '0) begin
      errors++; $display("FAIL midreset_outputs: grant %b send %b data %h busy %b, expected all 0", grant, uart_send, uart_data, arb_busy);
    end
    n0 = send_cyc.size();
    seen = 1'b0;
    for (int i = 0; i < FRAME + 10 && !seen; i++) begin tick(); seen = (fall_cyc.size() > 0); end
    checks++;
    if (!seen || send_cyc.size() !== n0) begin
      errors++; $display("FAIL midreset_hold: sends during busy %0d, expected 0", send_cyc.size() - n0);
    end
    wait_done(2 * (FRAME + 60), ok);
    model_ptr = 3;
    checks++;
    if (!ok || send_cyc.size() !== n0 + 1 || rx.size() !== 2 || ack_idx.size() !== 1) begin
      errors++; $display("FAIL midreset_resend: sends %0d rx %0d acks %0d, expected %0d 2 1", send_cyc.size(), rx.size(), ack_idx.size(), n0 + 1);
    end else begin
      checks++;
      if (send_cyc[n0] - fall_cyc[0] !== 1 || rx[1] !== d || ack_idx[0] !== 2) begin
        errors++; $display("FAIL midreset_data: latency %0d data %h ack %0d, expected 1 %h 2", send_cyc[n0] - fall_cyc[0], rx[1], ack_idx[0], d);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int total;
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      total = 0;
      for (int i = 0; i < N; i++) begin
        req_data[8*i +: 8] = 8'($urandom);
        pend[i] = $urandom_range(0, 2);
        total += pend[i];
      end
      if (total == 0) begin pend[r % N] = 1; total = 1; end
      for (int i = 0; i < N; i++) rem[i] = pend[i];
      for (int i = 0; i < N; i++) req[i] = (pend[i] > 0);
      predict_order();
      wait_done((total + 1) * (FRAME + 60), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL random_timeout: round %0d still busy", r); end
      check_service("random");
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_bad !== 0) begin
      errors++; $display("FAIL invariants: %0d violations (one-hot grant/ack/err, send without grant, data stability), expected 0", inv_bad);
    end
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_fairness();
    test_timeout();
    test_capture();
    test_reset_mid_frame();
    test_random();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
